// File: rtl/gmii_rx_monitor_pkg.sv
// Shared GMII receive constants, FSM encodings and the per-frame status record.
// The TX-side FCS generator reuses these definitions.
package gmii_rx_monitor_pkg;

    localparam logic [7:0]  GMII_PREAMBLE      = 8'h55;
    localparam logic [7:0]  GMII_SFD           = 8'hD5;
    localparam logic [7:0]  GMII_FALSE_CARRIER = 8'h0E;

    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    localparam logic [2:0]  WAIT_IDLE = 3'd0;
    localparam logic [2:0]  IDLE      = 3'd1;
    localparam logic [2:0]  PREAMBLE  = 3'd2;
    localparam logic [2:0]  DATA      = 3'd3;
    localparam logic [2:0]  DROP      = 3'd4;

    typedef struct packed {
        logic        ok;
        logic        crc_err;
        logic        sfd_err;
        logic        rx_err;
        logic        runt_err;
        logic [15:0] len;
    } rx_status_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/gmii_rx_monitor_if.sv
// GMII receive bus plus the monitor's status/counter outputs.
// The master side drives RXD/RX_DV/RX_ER; the slave side is the monitor.
interface gmii_rx_monitor_if #(
    parameter int CNT_W = 16
);
    logic [7:0]       RXD;
    logic             RX_DV;
    logic             RX_ER;
    logic             frame_done;
    logic             frame_ok;
    logic [15:0]      frame_len;
    logic             crc_err;
    logic             sfd_err;
    logic             rx_err;
    logic             runt_err;
    logic [CNT_W-1:0] good_frames;
    logic [CNT_W-1:0] bad_frames;
    logic [CNT_W-1:0] false_carriers;

    modport master (
        output RXD, RX_DV, RX_ER,
        input  frame_done, frame_ok, frame_len, crc_err, sfd_err, rx_err, runt_err,
        input  good_frames, bad_frames, false_carriers
    );

    modport slave (
        input  RXD, RX_DV, RX_ER,
        output frame_done, frame_ok, frame_len, crc_err, sfd_err, rx_err, runt_err,
        output good_frames, bad_frames, false_carriers
    );
endinterface

// File: rtl/gmii_rx_monitor_crc32_d8.sv
// Byte-wide Ethernet CRC-32 step: reflected polynomial, data consumed LSB first,
// no final inversion (the caller owns init and residue handling).
module crc32_d8
    import gmii_rx_monitor_pkg::*;
(
    input  logic [31:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);
    always_comb begin
        o_crc = i_crc;
        for (int i = 0; i < 8; i++) begin
            o_crc = (o_crc[0] ^ i_data[i]) ? ((o_crc >> 1) ^ CRC32_POLY) : (o_crc >> 1);
        end
    end
endmodule

// File: rtl/gmii_rx_monitor.sv
// GMII receive frame checker: delineates frames, checks preamble/SFD, length and FCS,
// and keeps saturating good/bad/false-carrier counters.
module gmii_rx_monitor
    import gmii_rx_monitor_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int MIN_LEN      = 64,
    parameter int MIN_PREAMBLE = 1
) (
    input  logic             RX_CLK,
    input  logic             mr_main_reset_n,
    gmii_rx_monitor_if.slave bus
);
    localparam logic [15:0] MIN_LEN_W = 16'(MIN_LEN);
    localparam logic [2:0]  MIN_PRE_W = (MIN_PREAMBLE > 7) ? 3'd7 : 3'(MIN_PREAMBLE);

    logic [2:0]       r_state;
    logic [2:0]       r_pre_cnt;
    logic [31:0]      r_crc;
    logic [15:0]      r_len;
    logic             r_sfd_err;
    logic             r_rx_err;
    logic             r_fc_prev;
    logic             r_done;
    rx_status_t       r_status;
    logic [CNT_W-1:0] r_good;
    logic [CNT_W-1:0] r_bad;
    logic [CNT_W-1:0] r_fc;

    logic [31:0]      w_crc_next;
    logic             w_in_frame;
    logic             w_end;
    logic             w_fc;
    rx_status_t       w_status;

    crc32_d8 u_crc32_d8 (
        .i_crc  (r_crc),
        .i_data (bus.RXD),
        .o_crc  (w_crc_next)
    );

    assign w_in_frame = (r_state == PREAMBLE) || (r_state == DATA) || (r_state == DROP);
    assign w_end      = w_in_frame && !bus.RX_DV;
    assign w_fc       = (r_state == IDLE) && !bus.RX_DV && bus.RX_ER && (bus.RXD == GMII_FALSE_CARRIER);

    // CRC and length checks only mean something once the SFD has been accepted.
    always_comb begin
        w_status.crc_err  = (r_state == DATA) && (r_crc != CRC32_RESIDUE);
        w_status.runt_err = (r_state == DATA) && (r_len < MIN_LEN_W);
        w_status.sfd_err  = r_sfd_err || (r_state == PREAMBLE);
        w_status.rx_err   = r_rx_err;
        w_status.len      = r_len;
        w_status.ok       = !(w_status.crc_err | w_status.sfd_err | w_status.rx_err | w_status.runt_err);
    end

    always_ff @(posedge RX_CLK or negedge mr_main_reset_n) begin
        if (!mr_main_reset_n) begin
            r_state   <= WAIT_IDLE;
            r_pre_cnt <= '0;
            r_crc     <= CRC32_INIT;
            r_len     <= '0;
            r_sfd_err <= 1'b0;
            r_rx_err  <= 1'b0;
            r_fc_prev <= 1'b0;
        end else begin
            r_fc_prev <= w_fc;
            if (w_in_frame && bus.RX_DV && bus.RX_ER) r_rx_err <= 1'b1;
            case (r_state)
                WAIT_IDLE: if (!bus.RX_DV) r_state <= IDLE;
                IDLE: begin
                    r_sfd_err <= 1'b0;
                    r_rx_err  <= 1'b0;
                    // The first byte is consumed here so a single idle gap loses nothing.
                    if (bus.RX_DV) begin
                        r_len     <= '0;
                        r_crc     <= CRC32_INIT;
                        r_pre_cnt <= 3'd1;
                        if (bus.RXD == GMII_PREAMBLE) begin
                            r_state <= PREAMBLE;
                        end else if (bus.RXD == GMII_SFD && MIN_PREAMBLE == 0) begin
                            r_state <= DATA;
                        end else begin
                            r_sfd_err <= 1'b1;
                            r_state   <= DROP;
                        end
                    end
                end
                PREAMBLE: begin
                    if (!bus.RX_DV) begin
                        r_state <= IDLE;
                    end else if (bus.RXD == GMII_PREAMBLE) begin
                        if (r_pre_cnt != 3'd7) r_pre_cnt <= r_pre_cnt + 3'd1;
                    end else if (bus.RXD == GMII_SFD && r_pre_cnt >= MIN_PRE_W) begin
                        r_state <= DATA;
                        r_crc   <= CRC32_INIT;
                        r_len   <= '0;
                    end else begin
                        r_sfd_err <= 1'b1;
                        r_state   <= DROP;
                    end
                end
                DATA: begin
                    if (!bus.RX_DV) begin
                        r_state <= IDLE;
                    end else begin
                        r_len <= sat_inc16(r_len);
                        r_crc <= w_crc_next;
                    end
                end
                DROP:    if (!bus.RX_DV) r_state <= IDLE;
                default: r_state <= WAIT_IDLE;
            endcase
        end
    end

    always_ff @(posedge RX_CLK or negedge mr_main_reset_n) begin
        if (!mr_main_reset_n) begin
            r_done   <= 1'b0;
            r_status <= '0;
            r_good   <= '0;
            r_bad    <= '0;
            r_fc     <= '0;
        end else begin
            r_done <= w_end;
            if (w_end) begin
                r_status <= w_status;
                if (w_status.ok) begin
                    if (r_good != '1) r_good <= r_good + 1'b1;
                end else begin
                    if (r_bad != '1) r_bad <= r_bad + 1'b1;
                end
            end
            if (w_fc && !r_fc_prev && r_fc != '1) r_fc <= r_fc + 1'b1;
        end
    end

    assign bus.frame_done     = r_done;
    assign bus.frame_ok       = r_status.ok;
    assign bus.frame_len      = r_status.len;
    assign bus.crc_err        = r_status.crc_err;
    assign bus.sfd_err        = r_status.sfd_err;
    assign bus.rx_err         = r_status.rx_err;
    assign bus.runt_err       = r_status.runt_err;
    assign bus.good_frames    = r_good;
    assign bus.bad_frames     = r_bad;
    assign bus.false_carriers = r_fc;

endmodule

// File: doc/gmii_rx_monitor.md
Name: gmii_rx_monitor

Overview:
- Receive-side GMII frame checker: the sink counterpart of the transmit stimulus source driving TXD/TX_EN/TX_ER into the PCS.
- Sits on the PCS receive outputs (RXD/RX_DV/RX_ER on RX_CLK), typically in loopback.
- Delineates each frame and checks preamble/SFD, length and Ethernet FCS (CRC-32).
- Reports per-frame status plus saturating good/bad/false-carrier counters for self-checking benches and on-board diagnostics.

Parameters:
- CNT_W, 16, width of each saturating event counter.
- MIN_LEN, 64, minimum legal frame length in bytes after the SFD, FCS included.
- MIN_PREAMBLE, 1, minimum number of 0x55 bytes required before the SFD.

Ports:
- RX_CLK  input  1  receive clock, 125 MHz; all logic on the rising edge.
- mr_main_reset_n  input  1  asynchronous, active-low reset.
- RXD  input  8  GMII receive data.
- RX_DV  input  1  GMII receive data valid.
- RX_ER  input  1  GMII receive error.
- frame_done  output  1  one-cycle pulse: frame ended, status outputs updated.
- frame_ok  output  1  last frame error-free.
- frame_len  output  16  bytes after SFD in last frame, FCS included; saturates at 0xFFFF.
- crc_err  output  1  last frame FCS residue mismatch.
- sfd_err  output  1  last frame had a bad or missing preamble/SFD.
- rx_err  output  1  last frame had RX_ER=1 while RX_DV=1.
- runt_err  output  1  last frame frame_len < MIN_LEN.
- good_frames  output  CNT_W  count of frames with frame_ok=1.
- bad_frames  output  CNT_W  count of frames with frame_ok=0.
- false_carriers  output  CNT_W  count of false-carrier events.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0, counters 0, CRC register 0xFFFFFFFF.
  - State goes to WAIT_IDLE.
- States:
  - WAIT_IDLE:
    - Stay while RX_DV=1; go to IDLE on RX_DV=0.
    - Never reports a frame, so a frame already in progress at reset release is discarded silently.
  - IDLE, with RX_DV=1:
    - RXD=0x55: go to PREAMBLE, pre_cnt=1.
    - RXD=0xD5: go to DATA if MIN_PREAMBLE=0, else set sfd_err and go to DROP.
    - Any other byte: set sfd_err, go to DROP.
  - IDLE, with RX_DV=0:
    - RX_ER=1 and RXD=0x0E: false_carriers++. Only a rising edge is counted, i.e. the previous cycle was not a false carrier.
    - RX_ER=1 with other RXD values (carrier extension etc.) is ignored.
  - PREAMBLE:
    - RXD=0x55: pre_cnt++, saturating at 7.
    - RXD=0xD5 and pre_cnt>=MIN_PREAMBLE: go to DATA, CRC <= 0xFFFFFFFF, length <= 0.
    - Otherwise: set sfd_err, go to DROP.
    - RX_DV=0 before the SFD: end the frame with sfd_err=1.
  - DATA, each cycle with RX_DV=1:
    - length++, saturating at 0xFFFF.
    - CRC <= crc32_d8(CRC, RXD), using reflected poly 0xEDB88320, LSB first.
    - RX_DV=0: end the frame.
  - DROP: wait for RX_DV=0, then end the frame. No CRC check; crc_err=0.
- RX_ER=1 with RX_DV=1 in any of PREAMBLE, DATA or DROP sets the rx_err flag; reception continues.
- Frame end, registered in the cycle where RX_DV=0 is first sampled:
  - frame_done=1 for exactly one cycle.
  - crc_err = (CRC != 0xDEBB20E3); evaluated only if the frame reached DATA.
  - runt_err = (frame_len < MIN_LEN); evaluated only if the frame reached DATA.
  - frame_ok = !(crc_err | sfd_err | rx_err | runt_err).
  - Exactly one of good_frames / bad_frames increments; both saturate at 2^CNT_W-1.
  - State goes to IDLE.
- Status outputs hold their values until the next frame_done. Internal error flags clear on entry to IDLE.
- Latency: frame_done is high exactly 1 RX_CLK after the last RX_DV=1 cycle.
- Back-to-back frames with a single RX_DV=0 cycle between them are legal. The IDLE transition and the next frame start must not lose a byte.
- frame_len is the raw byte count: 0 if RX_DV fell immediately after the SFD.
- Reset asserted mid-frame: no frame_done, counters cleared.

Decomposition:
- Shared include gmii_defs.vh holds:
  - GMII_PREAMBLE 8'h55, GMII_SFD 8'hD5, GMII_FALSE_CARRIER 8'h0E;
  - CRC32_POLY 32'hEDB88320, CRC32_INIT 32'hFFFFFFFF, CRC32_RESIDUE 32'hDEBB20E3;
  - state encodings WAIT_IDLE/IDLE/PREAMBLE/DATA/DROP.
- One combinational sub-module, crc32_d8: inputs crc[31:0] and data[7:0], output next crc. It is reused later by the TX-side FCS generator.

Test Plan:
- Good frame: 7x0x55, 0xD5, payload 0x00..0x3B (60 B), correct 4-byte FCS -> frame_done 1 cycle after RX_DV falls; frame_ok=1, frame_len=64, good_frames=1.
- Corrupted frame: same frame with payload byte 10 XOR 0x01 -> crc_err=1, frame_ok=0, bad_frames=1, good_frames unchanged.
- RX_ER mid-frame: good frame with RX_ER=1 on byte 20 -> rx_err=1, crc_err=0, frame_ok=0, frame_len=64.
- Framing errors:
  - 40-byte frame with valid FCS -> runt_err=1, frame_len=40.
  - Preamble 0x55,0x55,0xAA -> sfd_err=1, crc_err=0.
- Reset mid-frame: reset at byte 30, released with RX_DV still 1 -> no frame_done, counters 0. The next good frame reports frame_ok=1.
- False carrier: RX_DV=0, RX_ER=1, RXD=0x0E for 3 cycles, twice -> false_carriers=2, no frame_done.
- Back-to-back: two good frames separated by one idle cycle -> two frame_done pulses, good_frames=2.
